sisc_mem_arb: RTL and testbench
===============================

Name: sisc_mem_arb

Overview:
- Shares the single-ported unified SISC memory between two requesters: the instruction-fetch port (IR load in the fetch state) and the data port (LOD/STR in the mem state).
- Two-way round-robin arbiter plus access sequencer with a fixed memory read latency.
- Sits between the control FSM/datapath and the memory macro.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the m_en cycle to m_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  clock
- rst_f  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request; held high until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_gnt  out  1  one-cycle pulse: fetch request issued to memory
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request issued
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  out  DATA_W  loaded word
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the m_en cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_f low, asynchronous):
  - state = IDLE; last_owner = IF, so data wins the first tie.
  - Latency counter = 0.
  - All outputs 0, including rdata registers.
  - An access in flight is abandoned: no gnt or rvalid is produced afterwards, and the requester must re-request.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Neither request high: stay in IDLE.
  - Exactly one request high: that requester becomes owner.
  - Both high: owner is the requester that is not last_owner.
  - On the decision edge: latch owner, addr, we (fetch is always we = 0) and wdata. Go to ACCESS. Update last_owner to the new owner.
- ACCESS (exactly 1 cycle):
  - m_en = 1, m_we = latched we, m_addr/m_wdata = latched values.
  - Owner's gnt = 1; the requester may drop req or change address from the next cycle.
  - Store: next state is IDLE; no rvalid is produced.
  - Load: next state is WAIT, counter loaded with MEM_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture m_rdata into the owner's rdata register and go to RESP.
  - WAIT therefore lasts MEM_LAT cycles.
- RESP (1 cycle): owner's rvalid = 1 with rdata stable; then go to IDLE.
- rdata registers hold their value until the next load for the same port.
- m_en, m_we and gnt are 0 outside ACCESS. m_addr/m_wdata hold their last values.
- Latency, load request seen in IDLE at cycle 0:
  - gnt and m_en at cycle 1.
  - rvalid at cycle 2+MEM_LAT.
  - Back in IDLE at cycle 3+MEM_LAT.
  - Next grant no earlier than cycle 4+MEM_LAT.
- Store: gnt at cycle 1, IDLE at cycle 2.
- A request deasserted before its grant, after the decision edge, is still serviced to completion. Requesters must not do this.
- Requests arriving while busy wait in IDLE arbitration. Fairness: two continuously asserted requests alternate grants strictly.
- gnt and rvalid are never high on both ports in the same cycle.

Decomposition:
- Package sisc_mem_pkg: state encoding (IDLE = 0, ACCESS = 1, WAIT = 2, RESP = 3), owner encoding (OWN_IF = 0, OWN_D = 1), MEM_LAT range constants.
- One natural sub-module: arb2_rr.
  - Combinational two-way round-robin picker.
  - Inputs: req[1:0], last_owner. Outputs: pick_valid, pick.
- The FSM, counter and capture registers stay in sisc_mem_arb.

Test Plan:
- Reset then idle (MEM_LAT = 1): rst_f low for 2 cycles, no requests -> all outputs 0, busy 0. Release with if_req = 1, if_addr = 0x0010 -> if_gnt and m_en at cycle 1 with m_addr = 0x0010; memory model returns 0xA5A50010; if_rvalid = 1 with if_rdata = 0xA5A50010 at cycle 3.
- Store: d_req = 1, d_we = 1, d_addr = 0x0100, d_wdata = 0xDEADBEEF -> d_gnt, m_en = 1 and m_we = 1 at cycle 1 with those values; no d_rvalid; busy low at cycle 2.
- Simultaneous: if_req and d_req held high from reset -> grant order d, if, d, if. Loads only: gnt-to-gnt spacing = 3+MEM_LAT cycles. After a d store: if granted 2 cycles after d_gnt.
- Latency sweep: MEM_LAT = 4, fetch at 0x0020 -> if_rvalid exactly 6 cycles after the request was seen in IDLE; m_rdata sampled only on the last WAIT cycle (model drives garbage before it).
- Reset mid-operation: assert rst_f during WAIT of a d load -> no d_rvalid, state IDLE, d_rdata = 0. The re-issued request completes normally.
- Hold check: if_rdata is unchanged after if_rvalid through a following d load; d_rdata updates only on d_rvalid.

Source files
------------

// File: rtl/sisc_mem_pkg.sv
// Shared types and constants for the SISC unified-memory arbiter.
package sisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/arb2_rr.sv
// Two-way round-robin picker: a tie goes to the requester that did not win last.
import sisc_mem_pkg::*;

module arb2_rr (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       pick_valid,
  output logic       pick
);

  owner_t pick_sel;

  // req[0] is the fetch port, req[1] the data port
  always_comb begin
    pick_sel = OWN_IF;
    unique case (req)
      2'b01:   pick_sel = OWN_IF;
      2'b10:   pick_sel = OWN_D;
      2'b11:   pick_sel = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
      default: pick_sel = OWN_IF;
    endcase
  end

  assign pick_valid = |req;
  assign pick       = pick_sel;

endmodule

// File: rtl/sisc_mem_arb.sv
// Arbiter and access sequencer sharing the single-ported SISC memory between
// instruction fetch and data load/store; outputs come only from registered state.
import sisc_mem_pkg::*;

module sisc_mem_arb #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  state_t                state, state_nxt;
  owner_t                owner, last_owner;
  logic [LAT_CNT_W-1:0]  lat_cnt;
  logic                  we_q;
  logic                  pick_valid;
  logic                  pick_raw;
  owner_t                pick;

  arb2_rr u_arb (
    .req        ({d_req, if_req}),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick       (pick_raw)
  );

  assign pick = owner_t'(pick_raw);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      lat_cnt    <= '0;
      we_q       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick;
            last_owner <= pick;
            if (pick == OWN_D) begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              we_q    <= d_we;
            end else begin
              m_addr <= if_addr;
              we_q   <= 1'b0;
            end
          end
        end
        ACCESS: lat_cnt <= LAT_INIT;
        WAIT: begin
          // read data is only valid on the final WAIT cycle
          if (lat_cnt == '0) begin
            if (owner == OWN_D) d_rdata  <= m_rdata;
            else                if_rdata <= m_rdata;
          end else begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_q ? IDLE : WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_en      = (state == ACCESS);
    m_we      = m_en && we_q;
    if_gnt    = m_en && (owner == OWN_IF);
    d_gnt     = m_en && (owner == OWN_D);
    if_rvalid = (state == RESP) && (owner == OWN_IF);
    d_rvalid  = (state == RESP) && (owner == OWN_D);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: one instance at MEM_LAT=1, one at MEM_LAT=4.
module tb_sisc_mem_arb;

  logic        clk = 1'b0;
  logic        rst_f;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
  logic [31:0] if_rdata, d_rdata, m_wdata, m_rdata;
  logic [15:0] m_addr;

  logic        if_req4, d_req4, d_we4;
  logic [15:0] if_addr4, d_addr4;
  logic [31:0] d_wdata4;
  logic        if_gnt4, if_rvalid4, d_gnt4, d_rvalid4, m_en4, m_we4, busy4;
  logic [31:0] if_rdata4, d_rdata4, m_wdata4, m_rdata4;
  logic [15:0] m_addr4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(4)) u4 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req4), .if_addr(if_addr4), .if_gnt(if_gnt4), .if_rvalid(if_rvalid4), .if_rdata(if_rdata4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
    .m_en(m_en4), .m_we(m_we4), .m_addr(m_addr4), .m_wdata(m_wdata4), .m_rdata(m_rdata4),
    .busy(busy4)
  );

  // Memory model: returns {A5A5, addr} exactly MEM_LAT cycles after m_en, garbage otherwise.
  int unsigned pend1, pend4;
  logic [15:0] paddr1, paddr4;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pend1 <= 0; pend4 <= 0; paddr1 <= '0; paddr4 <= '0;
    end else begin
      if (m_en && !m_we) begin pend1 <= 1; paddr1 <= m_addr; end
      else if (pend1 != 0) pend1 <= pend1 - 1;
      if (m_en4 && !m_we4) begin pend4 <= 4; paddr4 <= m_addr4; end
      else if (pend4 != 0) pend4 <= pend4 - 1;
    end
  end

  assign m_rdata  = (pend1 == 1) ? {16'hA5A5, paddr1} : 32'hBAD0_BAD0;
  assign m_rdata4 = (pend4 == 1) ? {16'hA5A5, paddr4} : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_f = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    if_req4 = 0; if_addr4 = '0; d_req4 = 0; d_we4 = 0; d_addr4 = '0; d_wdata4 = '0;
    step(); step();

    chk("rst_if_gnt", if_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_m_en", m_en, 0);         chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);     chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);         chk("rst_busy4", busy4, 0);

    // fetch at MEM_LAT=1
    rst_f = 1'b1; if_req = 1; if_addr = 16'h0010;
    step();
    chk("f_if_gnt", if_gnt, 1); chk("f_m_en", m_en, 1); chk("f_m_we", m_we, 0);
    chk("f_m_addr", m_addr, 32'h0010); chk("f_d_gnt", d_gnt, 0); chk("f_busy", busy, 1);
    if_req = 0;
    step();
    chk("f_wait_gnt", if_gnt, 0); chk("f_wait_rvalid", if_rvalid, 0); chk("f_wait_m_en", m_en, 0);
    step();
    chk("f_rvalid", if_rvalid, 1); chk("f_rdata", if_rdata, 32'hA5A5_0010); chk("f_d_rvalid", d_rvalid, 0);
    step();
    chk("f_done_rvalid", if_rvalid, 0); chk("f_done_busy", busy, 0); chk("f_hold", if_rdata, 32'hA5A5_0010);

    // store
    d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("s_d_gnt", d_gnt, 1); chk("s_m_en", m_en, 1); chk("s_m_we", m_we, 1);
    chk("s_m_addr", m_addr, 32'h0100); chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF); chk("s_if_gnt", if_gnt, 0);
    d_req = 0; d_we = 0;
    step();
    chk("s_busy", busy, 0); chk("s_rvalid", d_rvalid, 0); chk("s_m_en_off", m_en, 0);
    chk("s_m_we_off", m_we, 0); chk("s_wdata_hold", m_wdata, 32'hDEAD_BEEF);
    step();
    chk("s_rvalid2", d_rvalid, 0); chk("s_d_rdata", d_rdata, 0);

    // both requesters held from reset: d, if, d, if
    rst_f = 1'b0; if_req = 1; if_addr = 16'h0030; d_req = 1; d_we = 0; d_addr = 16'h0040;
    step(); step();
    rst_f = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      chk($sformatf("rr_if_gnt_c%0d", c), if_gnt, (c == 5 || c == 13));
      chk($sformatf("rr_d_gnt_c%0d", c), d_gnt, (c == 1 || c == 9));
      chk($sformatf("rr_if_rvalid_c%0d", c), if_rvalid, (c == 7));
      chk($sformatf("rr_d_rvalid_c%0d", c), d_rvalid, (c == 3 || c == 11));
      chk($sformatf("rr_if_rdata_c%0d", c), if_rdata, (c >= 7) ? 32'hA5A5_0030 : 32'h0);
      chk($sformatf("rr_d_rdata_c%0d", c), d_rdata,
          (c >= 11) ? 32'hA5A5_0044 : (c >= 3) ? 32'hA5A5_0040 : 32'h0);
      if (c == 1) d_addr = 16'h0044;
      if (c == 5) if_addr = 16'h0034;
    end
    if_req = 0; d_req = 0;
    for (int i = 0; i < 20 && busy; i++) step();
    chk("rr_drain_busy", busy, 0);
    chk("rr_if_rdata_final", if_rdata, 32'hA5A5_0034);

    // store then fetch: fetch granted two cycles after d_gnt
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 32'h1234_5678;
    if_req = 1; if_addr = 16'h0050;
    step();
    chk("sf_d_gnt", d_gnt, 1); chk("sf_if_gnt0", if_gnt, 0);
    d_req = 0; d_we = 0;
    step();
    chk("sf_if_gnt1", if_gnt, 0); chk("sf_busy", busy, 0);
    step();
    chk("sf_if_gnt2", if_gnt, 1); chk("sf_m_addr", m_addr, 32'h0050); chk("sf_m_we", m_we, 0);
    if_req = 0;
    step(); step();
    chk("sf_rvalid", if_rvalid, 1); chk("sf_rdata", if_rdata, 32'hA5A5_0050);
    step();
    chk("sf_idle", busy, 0);

    // reset during WAIT of a data load
    d_req = 1; d_we = 0; d_addr = 16'h0080;
    step();
    chk("rm_d_gnt", d_gnt, 1);
    step();
    rst_f = 1'b0;
    #1;
    chk("rm_busy", busy, 0); chk("rm_d_rdata", d_rdata, 0); chk("rm_if_rdata", if_rdata, 0);
    chk("rm_d_rvalid", d_rvalid, 0); chk("rm_m_addr", m_addr, 0);
    step();
    chk("rm_no_rvalid", d_rvalid, 0);
    step();
    rst_f = 1'b1;
    step();
    chk("rm_regnt", d_gnt, 1);
    d_req = 0;
    step();
    chk("rm_wait_rvalid", d_rvalid, 0);
    step();
    chk("rm_rvalid", d_rvalid, 1); chk("rm_rdata", d_rdata, 32'hA5A5_0080);
    step();
    chk("rm_idle", busy, 0);

    // MEM_LAT=4 fetch
    if_req4 = 1; if_addr4 = 16'h0020;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("l4_if_gnt_c%0d", c), if_gnt4, (c == 1));
      chk($sformatf("l4_m_en_c%0d", c), m_en4, (c == 1));
      chk($sformatf("l4_rvalid_c%0d", c), if_rvalid4, (c == 6));
      chk($sformatf("l4_busy_c%0d", c), busy4, (c <= 6));
      if (c == 1) if_req4 = 0;
      if (c == 6) chk("l4_rdata", if_rdata4, 32'hA5A5_0020);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
